// File: rtl/rv_alu_pkg.sv
// Shared encodings for the RV execute-stage ALU: op codes, FSM states, M-extension flag bit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_alu_pkg;

  // op[4] selects the M extension; op[3] carries funct7[5]; op[2:0] is funct3.
  localparam int unsigned M_EXT_BIT = 4;

  // Base integer ops.
  localparam logic [4:0] OP_ADD  = 5'b0_0000;
  localparam logic [4:0] OP_SLL  = 5'b0_0001;
  localparam logic [4:0] OP_SLT  = 5'b0_0010;
  localparam logic [4:0] OP_SLTU = 5'b0_0011;
  localparam logic [4:0] OP_XOR  = 5'b0_0100;
  localparam logic [4:0] OP_SRL  = 5'b0_0101;
  localparam logic [4:0] OP_OR   = 5'b0_0110;
  localparam logic [4:0] OP_AND  = 5'b0_0111;
  localparam logic [4:0] OP_SUB  = 5'b0_1000;
  localparam logic [4:0] OP_SRA  = 5'b0_1101;

  // M-extension ops (op[3] is don't-care for these).
  localparam logic [4:0] OP_MUL    = 5'b1_0000;
  localparam logic [4:0] OP_MULH   = 5'b1_0001;
  localparam logic [4:0] OP_MULHSU = 5'b1_0010;
  localparam logic [4:0] OP_MULHU  = 5'b1_0011;
  localparam logic [4:0] OP_DIV    = 5'b1_0100;
  localparam logic [4:0] OP_DIVU   = 5'b1_0101;
  localparam logic [4:0] OP_REM    = 5'b1_0110;
  localparam logic [4:0] OP_REMU   = 5'b1_0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/rv_seq_alu_base.sv
// Combinational RV32I/RV64I base-op unit (add/sub, shifts, compares, logic).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the parent registers the result.
//
// Ports:
//   op_i     : {funct7[5], funct3}; unknown codes execute ADD
//   a_i, b_i : operands; shift amount is b_i[SHW-1:0]
//   result_o : op result
module rv_seq_alu_base
  import rv_alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b_i[SHW-1:0];

  always_comb begin
    result_o = a_i + b_i;
    case ({1'b0, op_i})
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_SLL:  result_o = a_i << shamt;
      OP_SRL:  result_o = a_i >> shamt;
      OP_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      OP_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      OP_XOR:  result_o = a_i ^ b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_AND:  result_o = a_i & b_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_seq_alu.sv
// Multi-cycle RV ALU: base ops in 1 cycle, M-extension via iterative shift-add / restoring divide.
// Latency: 1 cycle for base ops and divide special cases, XLEN+1 cycles for MUL*/DIV*/REM*.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; flush kills any op.
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   flush               : synchronous abort, returns to IDLE without out_valid
//   in_valid/in_ready   : request handshake, op/a/b sampled on accept
//   out_valid/out_ready : result handshake, result stable while waiting
//   busy                : high while iterating
module rv_seq_alu
  import rv_alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  localparam int unsigned SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned CW = SHW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  alu_state_e        state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;
  logic [XLEN-1:0]   result_q;
  // Mul: {partial product, remaining multiplier}. Div: {remainder, dividend/quotient}.
  logic [2*XLEN-1:0] acc_q;
  // Mul: multiplicand magnitude. Div: divisor magnitude.
  logic [XLEN-1:0]   mag_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        op_q;
  logic              neg_q;

  // ---------------------------------------------------------------- accept-side decode
  logic [XLEN-1:0] base_res;
  logic            is_m, is_div;
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;
  logic [2*XLEN-1:0] acc_d;
  logic [XLEN-1:0]   mag_d;
  logic              neg_d;

  rv_seq_alu_base #(.XLEN(XLEN)) u_base (
    .op_i     (op[3:0]),
    .a_i      (a),
    .b_i      (b),
    .result_o (base_res)
  );

  assign is_m   = op[M_EXT_BIT];
  assign is_div = op[2];

  // MUL low half is sign-agnostic, so it runs unsigned; MULHSU treats only a as signed.
  assign a_sgn = is_div ? ~op[0] : ((op[1:0] == 2'b01) || (op[1:0] == 2'b10));
  assign b_sgn = is_div ? ~op[0] : (op[1:0] == 2'b01);
  assign a_neg = a_sgn & a[XLEN-1];
  assign b_neg = b_sgn & b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign div_zero = (b == '0);
  assign div_ovf  = ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);

  // REM/REMU give a on divide-by-zero, 0 on overflow; DIV/DIVU give all-ones / a.
  always_comb begin
    special_res = '1;
    if (div_zero) special_res = op[1] ? a : '1;
    else          special_res = op[1] ? '0 : a;
  end

  always_comb begin
    acc_d = {{XLEN{1'b0}}, b_mag};
    mag_d = a_mag;
    neg_d = a_neg ^ b_neg;
    if (is_div) begin
      acc_d = {{XLEN{1'b0}}, a_mag};
      mag_d = b_mag;
      // Remainder takes the dividend's sign, quotient the XOR of both.
      neg_d = op[1] ? a_neg : (a_neg ^ b_neg);
    end
  end

  // ---------------------------------------------------------------- iteration step
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [XLEN:0]     div_rs, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_step;
  logic [2*XLEN-1:0] step_d;

  // Shift-add: add multiplicand to the upper half when the multiplier LSB is set,
  // then shift the whole register right; the carry drops into the top bit.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : '0);
  assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide: shift the next dividend bit into the remainder, subtract if it fits.
  assign div_rs   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff = div_rs - {1'b0, mag_q};
  assign div_ge   = ~div_diff[XLEN];
  assign div_step = {(div_ge ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0]),
                     acc_q[XLEN-2:0], div_ge};

  assign step_d = op_q[2] ? div_step : mul_step;

  // ---------------------------------------------------------------- sign fix-up
  logic [2*XLEN-1:0] mul_fix;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   fin_d;

  assign mul_fix = neg_q ? -step_d : step_d;
  assign quo     = step_d[XLEN-1:0];
  assign rem     = step_d[2*XLEN-1:XLEN];

  always_comb begin
    fin_d = mul_fix[2*XLEN-1:XLEN];
    if (op_q[2]) begin
      if (op_q[1]) fin_d = neg_q ? -rem : rem;
      else         fin_d = neg_q ? -quo : quo;
    end else if (op_q == OP_MUL[2:0]) begin
      fin_d = mul_fix[XLEN-1:0];
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      acc_q       <= '0;
      mag_q       <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
    end else if (flush) begin
      // Kill wins over accept and completion; result keeps its last value.
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (!is_m) begin
              result_q    <= base_res;
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
            end else if (is_div && (div_zero || div_ovf)) begin
              result_q    <= special_res;
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
            end else begin
              acc_q   <= acc_d;
              mag_q   <= mag_d;
              neg_q   <= neg_d;
              op_q    <= op[2:0];
              cnt_q   <= '0;
              state_q <= ST_BUSY;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          acc_q <= step_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            result_q    <= fin_d;
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;

endmodule

// File: tb/tb_rv_seq_alu.sv
// Directed self-checking bench for rv_seq_alu (XLEN=32).
// Latency: checks 1-cycle base/special ops and 33-cycle M ops.
// Backpressure: exercises out_ready hold, flush mid-BUSY and reset mid-BUSY.
module tb_rv_seq_alu;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int errors;
  int checks;

  rv_seq_alu #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op_r),
    .a         (a_r),
    .b         (b_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op_r     = o;
    a_r      = x;
    b_r      = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from accept (accept edge = 1) until out_valid, bounded.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_idle"}, in_ready, 1'b1);
  endtask

  task automatic run(input string tag, input logic [4:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int lat;
    start(o, x, y);
    wait_done(lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk(tag, result, exp);
    release_out(tag);
  endtask

  initial begin
    int lat;
    int vld_seen;
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_r      = 5'b0;
    a_r       = 32'h0;
    b_r       = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_busy", busy, 1'b0);

    // Base ops, latency 1
    run("add",    5'b00000, 32'd7,        32'd5,        32'd12,       1);
    run("sub",    5'b01000, 32'd5,        32'd7,        32'hFFFFFFFE, 1);
    run("sra",    5'b01101, 32'h80000000, 32'h24,       32'hF8000000, 1);
    run("sll",    5'b00001, 32'd1,        32'h3F,       32'h80000000, 1);
    run("slt",    5'b00010, 32'hFFFFFFFF, 32'd1,        32'd1,        1);
    run("sltu",   5'b00011, 32'hFFFFFFFF, 32'd1,        32'd0,        1);
    run("and",    5'b00111, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1);
    run("dflt",   5'b01001, 32'd3,        32'd4,        32'd7,        1);

    // M ops, latency 33
    run("mulh",   5'b10001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run("mulhu",  5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run("mul",    5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
    run("mulhsu", 5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run("div",    5'b10100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run("rem",    5'b10110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run("divu",   5'b10101, 32'd100,      32'd7,        32'd14,       33);
    run("remu",   5'b10111, 32'd100,      32'd7,        32'd2,        33);

    // Divide special cases, latency 1
    run("divu0",  5'b10101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run("remu0",  5'b10111, 32'd5,        32'd0,        32'd5,        1);
    run("divovf", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run("removf", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1);

    // Backpressure: hold result for 5 cycles while a competing request is offered
    start(5'b00000, 32'h10, 32'h20);
    wait_done(lat);
    chk("bp_lat", lat, 1);
    @(negedge clk);
    op_r     = 5'b01000;
    a_r      = 32'd9;
    b_r      = 32'd9;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_result", result, 32'h30);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    release_out("bp");

    // Flush in BUSY cycle 10 of a DIVU
    start(5'b10101, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    chk("fl_busy", busy, 1'b1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("fl_in_ready", in_ready, 1'b1);
    chk("fl_busy_low", busy, 1'b0);
    chk("fl_out_valid", out_valid, 1'b0);
    chk("fl_result_held", result, 32'h30);
    vld_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) vld_seen++;
    end
    chk("fl_no_valid", vld_seen, 0);
    run("fl_add", 5'b00000, 32'd1, 32'd1, 32'd2, 1);

    // Reset pulsed mid-BUSY
    start(5'b10000, 32'd3, 32'd5);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rb_out_valid", out_valid, 1'b0);
    chk("rb_busy", busy, 1'b0);
    chk("rb_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rb_in_ready", in_ready, 1'b1);
    run("rb_mul", 5'b10000, 32'd3, 32'd5, 32'd15, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_seq_alu.md
Name: rv_seq_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle RV32I ALU. Executes all RV base integer ops plus the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Multiplication and division are iterative shift-add and restoring-division datapaths.
- Sits in the execute stage behind a valid/ready handshake, so the core stalls on in_ready/out_valid.
- Supports synchronous flush for pipeline kills.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of any in-flight op
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- op  in  5  {m_ext, funct7[5], funct3}
- a  in  XLEN  operand A (rs1)
- b  in  XLEN  operand B (rs2/imm)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  result, held stable while out_valid=1 and out_ready=0
- busy  out  1  high in BUSY state

Behaviour:
- Reset (rst_n=0, async): state=IDLE, out_valid=0, result=0, busy=0, internal counters/accumulators=0. in_ready=1 once reset is released.
- States: IDLE, BUSY, DONE. in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state==BUSY).
- Accept: in IDLE with in_valid=1, latch a, b, op at the edge.
- Base op (op[4]=0): result computed and registered at the accept edge, then state=DONE. Latency 1.
- Base encodings, op[3:0]:
  - 0000 ADD, 1000 SUB
  - 0001 SLL, 0101 SRL, 1101 SRA; shift amount is b[SHW-1:0]
  - 0010 SLT (signed), 0011 SLTU
  - 0100 XOR, 0110 OR, 0111 AND
  - any other code executes ADD
- M encodings, op[2:0] (op[3] ignored): 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- M op: operands converted to magnitudes per signedness. BUSY for exactly XLEN cycles, one bit per cycle, using a 2·XLEN product register or an XLEN remainder/quotient pair. Sign fix-up is applied on the last BUSY edge, then state=DONE. Latency XLEN+1 (33 for XLEN=32).
- MUL returns the low XLEN bits of the product; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide special cases skip BUSY, latency 1:
  - b==0: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow (a==most-negative, b==-1): DIV gives a; REM gives 0.
- DONE: result held. On out_ready=1 → IDLE. There is no accept in the same cycle (in_ready=0 in DONE), so max throughput is one op per 2 cycles.
- flush=1: next state=IDLE and out_valid deasserts, from any state. Flush has priority over accept and completion. result keeps its last value and a killed op never produces out_valid.
- Reset mid-BUSY: immediate return to the reset values above.
- in_valid while not IDLE: ignored; the requester must hold it until in_ready.
- All arithmetic wraps modulo 2^XLEN. The iteration counter is $clog2(XLEN)+1 bits.

Decomposition:
- Shared package rv_alu_pkg: op encoding localparams (OP_ADD…OP_REMU), state encodings, and the M_EXT bit index. Used by the decoder and this block.
- One sub-module: rv_seq_alu_base, a combinational base-op unit with the 10-op table above, parametrised by XLEN. The top holds the FSM and the mul/div iterators.

Test Plan:
- Reset → in_ready=1, out_valid=0, result=0. Then ADD a=7, b=5 → out_valid one cycle after accept, result=12. With out_ready=1 → back to IDLE next cycle.
- SRA a=0x80000000, b=0x24 (shift 4) → 0xF8000000. SLT a=0xFFFFFFFF, b=1 → 1. SLTU with the same operands → 0.
- MULH a=0x80000000, b=0x80000000 → 0x40000000 after exactly 33 cycles. MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE. MUL with the same operands → 0x00000001.
- DIV a=-7, b=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU a=5, b=0 → 0xFFFFFFFF at latency 1. DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000.
- Backpressure: complete any op with out_ready=0 for 5 cycles → result and out_valid stable, in_ready=0 throughout.
- Flush at BUSY cycle 10 of a DIVU → IDLE next cycle, no out_valid. A following ADD 1+1 → result 2. Repeat with rst_n pulsed mid-BUSY → reset values.
